// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and the ALU operation sequencer.
// The requester drives the master side; the sequencer sits on the slave side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// FSM that steps one ALU operation through load A, load B, execute, capture and respond.
// All outputs are registered; each transition sets the outputs belonging to the state entered.
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1,
    parameter int NUM_OPS = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_op_sequencer_if.slave        bus,
    output logic                     ra_load,
    output logic                     rb_load,
    output logic [WIDTH-1:0]         opnd_d,
    output logic [OPW-1:0]           alu_op,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_cout,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        EXEC    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [OPW:0] NUM_OPS_W = (OPW+1)'(NUM_OPS);
    localparam logic [3:0]   LAT_M1    = 4'(ALU_LAT - 1);

    state_t           state_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       cnt_q;
    logic             req_ready_q;
    logic             ra_load_q;
    logic             rb_load_q;
    logic [WIDTH-1:0] opnd_q;
    logic [OPW-1:0]   alu_op_q;
    logic             busy_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            ra_load_q    <= 1'b0;
            rb_load_q    <= 1'b0;
            opnd_q       <= '0;
            alu_op_q     <= '0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            // Load strobes are single-cycle pulses; opnd_d only carries data with a strobe.
            ra_load_q <= 1'b0;
            rb_load_q <= 1'b0;
            opnd_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        op_q        <= bus.req_op;
                        b_q         <= bus.req_b;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if ({1'b0, bus.req_op} < NUM_OPS_W) begin
                            state_q   <= LOAD_A;
                            ra_load_q <= 1'b1;
                            opnd_q    <= bus.req_a;
                        end else begin
                            state_q      <= DONE;
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_result_q <= '0;
                            rsp_carry_q  <= 1'b0;
                            rsp_zero_q   <= 1'b0;
                        end
                    end
                end
                LOAD_A: begin
                    state_q   <= LOAD_B;
                    rb_load_q <= 1'b1;
                    opnd_q    <= b_q;
                end
                LOAD_B: begin
                    state_q  <= EXEC;
                    cnt_q    <= LAT_M1;
                    alu_op_q <= op_q;
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CAPTURE: begin
                    state_q      <= DONE;
                    alu_op_q     <= '0;
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= alu_y;
                    rsp_carry_q  <= alu_cout;
                    rsp_zero_q   <= (alu_y == '0);
                    rsp_err_q    <= 1'b0;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    alu_op_q    <= '0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign ra_load        = ra_load_q;
    assign rb_load        = rb_load_q;
    assign opnd_d         = opnd_q;
    assign alu_op         = alu_op_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: operand-register/ALU model around the DUT, directed and random
// requests compared against a cycle schedule and results computed straight from op/A/B.
module tb_alu_op_sequencer;

    localparam int WIDTH   = 8;
    localparam int OPW     = 3;
    localparam int ALU_LAT = 4;
    localparam int NUM_OPS = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    logic             ra_load, rb_load, busy, alu_cout;
    logic [WIDTH-1:0] opnd_d, alu_y;
    logic [OPW-1:0]   alu_op;

    alu_op_sequencer #(
        .WIDTH(WIDTH), .OPW(OPW), .ALU_LAT(ALU_LAT), .NUM_OPS(NUM_OPS)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ra_load  (ra_load),
        .rb_load  (rb_load),
        .opnd_d   (opnd_d),
        .alu_op   (alu_op),
        .alu_y    (alu_y),
        .alu_cout (alu_cout),
        .busy     (busy)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, 5 NOT A
    function automatic logic [WIDTH:0] ref_alu(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            default: return '0;
        endcase
    endfunction

    logic [WIDTH-1:0] ra_m = '0;
    logic [WIDTH-1:0] rb_m = '0;
    always @(posedge clk) begin
        if (ra_load) ra_m <= opnd_d;
        if (rb_load) rb_m <= opnd_d;
    end
    always_comb {alu_cout, alu_y} = ref_alu(alu_op, ra_m, rb_m);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_ra_load"},   32'(ra_load),       32'd0);
        check({tag, "_rb_load"},   32'(rb_load),       32'd0);
        check({tag, "_alu_op"},    32'(alu_op),        32'd0);
        check({tag, "_opnd_d"},    32'(opnd_d),        32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_rsp_result"},32'(bus.rsp_result),32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    endtask

    // One full transaction from an IDLE negedge through the response handshake.
    task automatic run_req(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int stall, input bit chk_space);
        bit               legal;
        int               done_n;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] exp_res;
        logic             exp_c, exp_z, exp_e;
        legal   = (int'(op) < NUM_OPS);
        r       = legal ? ref_alu(op, a, b) : '0;
        exp_res = r[WIDTH-1:0];
        exp_c   = r[WIDTH];
        exp_z   = legal && (exp_res == '0);
        exp_e   = !legal;
        done_n  = legal ? 4 + ALU_LAT : 1;

        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        for (int n = 1; n <= done_n; n++) begin
            @(negedge clk);
            check("ra_load",   32'(ra_load),       32'(legal && n == 1));
            check("rb_load",   32'(rb_load),       32'(legal && n == 2));
            check("opnd_d",    32'(opnd_d),
                  32'((legal && n == 1) ? a : (legal && n == 2) ? b : '0));
            check("alu_op",    32'(alu_op),
                  32'((legal && n >= 3 && n <= 3 + ALU_LAT) ? op : '0));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(n == done_n));
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check("busy",      32'(busy),          32'd1);
            // Garbage on the request side and stray rsp_ready while busy must be ignored.
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op    = OPW'($urandom);
            bus.req_a     = WIDTH'($urandom);
            bus.req_b     = WIDTH'($urandom);
            bus.rsp_ready = (n == done_n) ? (stall == 0) : 1'($urandom_range(0, 1));
        end
        check("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
        check("rsp_carry",  32'(bus.rsp_carry),  32'(exp_c));
        check("rsp_zero",   32'(bus.rsp_zero),   32'(exp_z));
        check("rsp_err",    32'(bus.rsp_err),    32'(exp_e));
        if (chk_space) check("rsp_spacing", 32'(cyc - last_rsp), 32'(5 + ALU_LAT));
        last_rsp = cyc;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_rsp_valid",  32'(bus.rsp_valid),  32'd1);
            check("stall_rsp_result", 32'(bus.rsp_result), 32'(exp_res));
            check("stall_rsp_carry",  32'(bus.rsp_carry),  32'(exp_c));
            check("stall_rsp_err",    32'(bus.rsp_err),    32'(exp_e));
            check("stall_req_ready",  32'(bus.req_ready),  32'd0);
            bus.rsp_ready = (s == stall - 1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("post_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("post_req_ready",  32'(bus.req_ready),  32'd1);
        check("post_busy",       32'(busy),           32'd0);
        check("post_rsp_result", 32'(bus.rsp_result), 32'(exp_res));
        check("post_rsp_err",    32'(bus.rsp_err),    32'(exp_e));
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_init");

        // Reset while in EXEC discards the operation.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_a     = 8'h33;
        bus.req_b     = 8'h44;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle_after_rst");

        run_req(3'd0, 8'h0F, 8'h01, 0, 1'b0);
        run_req(3'd0, 8'hFF, 8'h01, 0, 1'b0);
        run_req(3'd1, 8'h05, 8'h07, 1, 1'b0);
        run_req(3'd1, 8'h07, 8'h05, 0, 1'b0);
        run_req(3'd2, 8'hF0, 8'h3C, 0, 1'b0);
        run_req(3'd3, 8'hA0, 8'h05, 2, 1'b0);
        run_req(3'd4, 8'h5A, 8'h5A, 0, 1'b0);
        run_req(3'd5, 8'h0F, 8'h00, 0, 1'b0);
        run_req(3'd7, 8'h12, 8'h34, 0, 1'b0);
        run_req(3'd6, 8'h00, 8'h00, 3, 1'b0);

        // Backpressure, then back-to-back requests with rsp_ready held high.
        run_req(3'd0, 8'h80, 8'h80, 10, 1'b0);
        run_req(3'd0, 8'h11, 8'h22, 0, 1'b0);
        run_req(3'd1, 8'h40, 8'h01, 0, 1'b1);
        run_req(3'd4, 8'hFF, 8'h0F, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_req(OPW'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
